// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit owning HI/LO, with
// shift-add multiply and restoring divide retiring one bit per cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, mq, opd, a_raw, am, bm, nxt_acc, nxt_mq, dif, q_fix, r_fix;
  logic [WIDTH:0] sum, sh;
  logic [2*WIDTH-1:0] pn;
  logic is_div, neg_p, neg_r, bz, sa, sb, ge, go;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt_state;
  end
  always_comb begin
    nxt_state = state == IDLE ? ((start && !op[2]) ? RUN : IDLE)
              : state == RUN ? ((cnt == CNT_W'(WIDTH - 1)) ? FINISH : RUN)
              : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
  end
  // acc/mq hold {hi,lo} of the product while multiplying, and remainder/quotient while dividing
  always_comb begin
    go = state == IDLE && start;
    sa = op[0] & a[WIDTH-1];
    sb = op[0] & b[WIDTH-1];
    am = sa ? -a : a;
    bm = sb ? -b : b;
    sum = {1'b0, acc} + (mq[0] ? {1'b0, opd} : '0);
    sh = {acc, mq[WIDTH-1]};
    ge = sh >= {1'b0, opd};
    dif = sh[WIDTH-1:0] - opd;
    nxt_acc = is_div ? (ge ? dif : sh[WIDTH-1:0]) : sum[WIDTH:1];
    nxt_mq = is_div ? {mq[WIDTH-2:0], ge} : {sum[0], mq[WIDTH-1:1]};
    pn = neg_p ? -{acc, mq} : {acc, mq};
    q_fix = neg_p ? -mq : mq;
    r_fix = neg_r ? -acc : acc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      acc <= '0;
      mq <= '0;
      opd <= '0;
      a_raw <= '0;
      is_div <= 1'b0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      bz <= 1'b0;
    end else begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      if (go && op == 3'b100) begin
        hi <= a;
        done <= 1'b1;
      end
      if (go && op == 3'b101) begin
        lo <= a;
        done <= 1'b1;
      end
      if (go && !op[2]) begin
        is_div <= op[1];
        neg_p <= sa ^ sb;
        neg_r <= sa;
        acc <= '0;
        mq <= op[1] ? am : bm;
        opd <= op[1] ? bm : am;
        a_raw <= a;
        bz <= b == '0;
        cnt <= '0;
      end
      if (state == RUN) begin
        acc <= nxt_acc;
        mq <= nxt_mq;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == FINISH) begin
        done <= 1'b1;
        div_by_zero <= is_div && bz;
        hi <= is_div ? (bz ? a_raw : r_fix) : pn[2*WIDTH-1:WIDTH];
        lo <= is_div ? (bz ? '1 : q_fix) : pn[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit at WIDTH=32.
module tb_mul_div_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] last_hi = '0, last_lo = '0;
  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dz; int lat; int t0;} exp_t;
  exp_t q[$];
  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz, input int lat);
    exp_t e;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    e.hi = eh;
    e.lo = el;
    e.dz = edz;
    e.lat = lat;
    e.t0 = cyc;
    q.push_back(e);
    last_hi = eh;
    last_lo = el;
    start = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 0);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        chk("pending_on_done", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("dz", div_by_zero, e.dz);
          chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        end
      end else begin
        chk("dz_idle", div_by_zero, 0);
      end
    end
  end
  initial begin
    logic [31:0] ph, pl;
    int n;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(3'b100, 32'h12345678, 32'h0, 32'h12345678, last_lo, 1'b0, 0);
    chk("mthi_busy", busy, 0);
    issue(3'b101, 32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 0);
    chk("mtlo_busy", busy, 0);
    drain();
    start = 1'b1;
    op = 3'b110;
    a = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rsv_hi", hi, 32'h12345678);
    chk("rsv_lo", lo, 32'h9ABCDEF0);
    chk("rsv_busy", busy, 0);
    issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    n = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) n++;
    end
    chk("busy_cycles", 64'(n), 33);
    drain();
    issue(3'b001, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
    drain();
    issue(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 33);
    drain();
    issue(3'b011, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    drain();
    issue(3'b010, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0, 33);
    drain();
    issue(3'b010, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF, 1'b1, 33);
    drain();
    issue(3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33);
    drain();
    ph = last_hi;
    pl = last_lo;
    issue(3'b000, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0, 33);
    repeat (8) @(posedge clk);
    #1;
    chk("hold_hi", hi, ph);
    chk("hold_lo", lo, pl);
    start = 1'b1;
    op = 3'b010;
    a = 32'h1;
    b = 32'h1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    issue(3'b000, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0, 33);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    q.delete();
    last_hi = '0;
    last_lo = '0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_done", done, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_hi", hi, 0);
    chk("post_rst_busy", busy, 0);
    issue(3'b000, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0, 33);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parameterised iterative multiply/divide unit for the multi-cycle MIPS datapath. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers.
- Sits beside the combinational ALU. The controller issues a start pulse, stalls while busy is high, and reads hi/lo after done.
- Generalises the ALU to WIDTH-bit operands with sequential shift-add / restoring-division engines.

Parameters:
- WIDTH, 32, operand, HI and LO width (>=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only in IDLE.
- op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 reserved.
- a  input  WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO source).
- b  input  WIDTH  rt operand (multiplier or divisor).
- busy  output  1  high while an iterative op is in flight.
- done  output  1  one-cycle pulse; HI/LO are updated and visible in the same cycle.
- div_by_zero  output  1  valid only with done; set for DIV/DIVU with b==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter and internal operand registers are cleared.
  - Reset mid-operation aborts the op: no HI/LO write and no done.
- States: IDLE, RUN, FINISH.
- Acceptance: start=1 in IDLE with a valid op, sampled at edge E.
  - start is ignored in RUN/FINISH.
  - Reserved ops are ignored (no state change, no done).
- MTHI/MTLO:
  - At edge E, hi<=a (MTHI) or lo<=a (MTLO); the other register holds.
  - done=1 for the cycle after E; busy stays 0; state stays IDLE.
- MULT/MULTU/DIV/DIVU:
  - At edge E: capture operands, go to RUN, busy=1, counter=0.
  - Signed ops convert both operands to magnitudes and record the sign fixups.
  - Exactly WIDTH iterations run on edges E+1..E+WIDTH, one bit per cycle, then the unit enters FINISH.
  - At edge E+WIDTH+1: write hi/lo, busy=0, done=1 for one cycle, return to IDLE.
  - Total latency is WIDTH+1 cycles from acceptance to done.
  - A new start may be accepted in the done cycle itself.
- HI/LO hold their old values for the whole of RUN and FINISH.
- Multiply:
  - {hi,lo} = full 2*WIDTH-bit product.
  - MULT treats operands as two's complement; the product is negated when the signs differ.
- Divide:
  - lo = quotient, hi = remainder.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend; the remainder magnitude is less than the divisor magnitude.
- Divide by zero:
  - Iteration still runs the full WIDTH cycles (fixed latency).
  - lo = all ones, hi = a unchanged, div_by_zero=1 with done.
  - div_by_zero is 0 in all other done cycles and whenever done=0.
- Signed overflow: DIV with a = most-negative value and b = -1 gives lo = most-negative value, hi=0, div_by_zero=0.
- Registers: all outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 33 cycles after the accepting edge; hi=0xFFFFFFFE lo=0x00000001; busy high for 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. MULT a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3 hi=1.
- DIVU a=5 b=0 -> lo=0xFFFFFFFF hi=5, div_by_zero=1 for the done cycle only. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0, div_by_zero=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on the next cycle -> each produces a 1-cycle done with busy=0; hi/lo hold those values. Reserved op 110 -> no done, hi/lo unchanged.
- Start MULTU 3*4, then pulse start DIVU 1/1 at cycle 10 -> second start ignored; result hi=0 lo=12. Re-issue 3*4, drop rst_n at cycle 15 -> hi=lo=0, busy=0 immediately, no done; a new op after reset completes normally.
